// File: rtl/calc_seq.sv
// Calculator sequencer: synchronizes and debounces the panel buttons, then issues one ALU op per execute press.
// Define CALC_SEQ_SAT_EN to saturate write-back to the signed 16-bit range and enable the sticky ovf flag.
module calc_seq #(
  parameter int DB_CYCLES = 16,
  parameter int ALU_LAT   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        btnu_i,
  input  logic        btnd_i,
  input  logic        btnl_i,
  input  logic        btnc_i,
  input  logic        btnr_i,
  input  logic [15:0] sw_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] alu_op1_o,
  output logic [31:0] alu_op2_o,
  output logic [2:0]  op_sel_o,
  output logic [15:0] led_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o
);

  localparam int DbW  = $clog2(DB_CYCLES + 1);
  localparam int LatW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Packed input bundle: {btnu, btnd, btnl, btnc, btnr, sw[15:0]}
  logic [20:0] meta_q, sync_q;
  logic [1:0]  btnSync;
  logic [2:0]  opSelSync;
  logic [15:0] swSync;

  // Index 1 is the clear button, index 0 the execute button
  logic [1:0]           dbLevel_q, dbLevel_d;
  logic [1:0][DbW-1:0]  dbCnt_q, dbCnt_d;
  logic [1:0]           press_q, press_d;
  logic                 clrPress, exePress;

  state_t          state_q;
  logic [LatW-1:0] cnt_q;
  logic [15:0]     acc_q, accWb;
  logic [31:0]     op1_q, op2_q;
  logic [2:0]      opSel_q;
  logic            busy_q, done_q, ovf_q, wbSat;

  assign btnSync   = sync_q[20:19];
  assign opSelSync = sync_q[18:16];
  assign swSync    = sync_q[15:0];
  assign clrPress  = press_q[1];
  assign exePress  = press_q[0];

  always_comb begin
    dbLevel_d = dbLevel_q;
    dbCnt_d   = '0;
    press_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (btnSync[i] != dbLevel_q[i]) begin
        if (dbCnt_q[i] == DbW'(DB_CYCLES - 1)) begin
          dbLevel_d[i] = btnSync[i];
          press_d[i]   = btnSync[i];
        end else begin
          dbCnt_d[i] = dbCnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q    <= '0;
      sync_q    <= '0;
      dbLevel_q <= '0;
      dbCnt_q   <= '0;
      press_q   <= '0;
    end else begin
      meta_q    <= {btnu_i, btnd_i, btnl_i, btnc_i, btnr_i, sw_i};
      sync_q    <= meta_q;
      dbLevel_q <= dbLevel_d;
      dbCnt_q   <= dbCnt_d;
      press_q   <= press_d;
    end
  end

`ifdef CALC_SEQ_SAT_EN
  // Result fits in 16 signed bits only when bits 31..15 are all copies of the sign
  assign wbSat = !((&alu_result_i[31:15]) || !(|alu_result_i[31:15]));
  assign accWb = wbSat ? (alu_result_i[31] ? 16'h8000 : 16'h7FFF) : alu_result_i[15:0];
`else
  logic unusedAluHi;
  assign unusedAluHi = ^alu_result_i[31:16];
  assign wbSat       = 1'b0;
  assign accWb       = alu_result_i[15:0];
`endif

  // Clear has priority over everything, including an operation already in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      opSel_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clrPress) begin
        acc_q   <= '0;
        ovf_q   <= 1'b0;
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (exePress) begin
              op1_q   <= {{16{acc_q[15]}}, acc_q};
              op2_q   <= {{16{swSync[15]}}, swSync};
              opSel_q <= opSelSync;
              cnt_q   <= '0;
              state_q <= WAIT;
              busy_q  <= 1'b1;
            end
          end
          WAIT: begin
            cnt_q <= cnt_q + LatW'(1);
            if (cnt_q == LatW'(ALU_LAT - 1)) begin
              acc_q   <= accWb;
              ovf_q   <= ovf_q | wbSat;
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign alu_op1_o = op1_q;
  assign alu_op2_o = op2_q;
  assign op_sel_o  = opSel_q;
  assign led_o     = acc_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq: sample-window debounce model plus transaction-level accumulator model.
// Directed button sequences with hand-computed literal checks on top of the per-cycle comparison.
module tb_calc_seq;

  localparam int DB  = 4;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst, btnu, btnd, btnl, btnc, btnr;
  logic [15:0] sw;
  logic [31:0] aluResult, aluOp1, aluOp2;
  logic [2:0]  opSel;
  logic [15:0] led;
  logic        busy, done, ovf;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  bit busySeen = 0;

  calc_seq #(.DB_CYCLES(DB), .ALU_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .btnu_i(btnu), .btnd_i(btnd), .btnl_i(btnl), .btnc_i(btnc), .btnr_i(btnr),
    .sw_i(sw), .alu_result_i(aluResult),
    .alu_op1_o(aluOp1), .alu_op2_o(aluOp2), .op_sel_o(opSel),
    .led_o(led), .busy_o(busy), .done_o(done), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] aluFn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    return (s == 3'b001) ? a - b : a + b;
  endfunction

  assign aluResult = aluFn(aluOp1, aluOp2, opSel);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples delayed two edges, a button level flips once the last DB samples all disagree
  typedef struct packed {
    logic        u;
    logic        d;
    logic [2:0]  sel;
    logic [15:0] sw;
  } inSample_t;
  typedef logic bitQ_t[$];

  inSample_t   rawHist[$];
  bitQ_t       winU, winD;
  logic        lvlU, lvlD, pClr, pExe;
  logic [15:0] mAcc;
  logic [31:0] mOp1, mOp2;
  logic [2:0]  mSel;
  logic        mOvf, mDone, mBusy, mInDone;
  int          mRemain;
  bit          modelValid = 0;

  function automatic bit allOpposite(input bitQ_t win, input logic lvl);
    foreach (win[i]) if (win[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    inSample_t   cur, s;
    logic [31:0] res;
    logic        newClr, newExe;
    if (rst) begin
      rawHist.delete(); winU.delete(); winD.delete();
      lvlU = 0; lvlD = 0; pClr = 0; pExe = 0;
      mAcc = 0; mOp1 = 0; mOp2 = 0; mSel = 0;
      mOvf = 0; mDone = 0; mBusy = 0; mInDone = 0; mRemain = 0;
      modelValid = 1;
    end else begin
      cur.u = btnu; cur.d = btnd; cur.sel = {btnl, btnc, btnr}; cur.sw = sw;
      rawHist.push_back(cur);
      if (rawHist.size() > 3) void'(rawHist.pop_front());
      if (rawHist.size() == 3) s = rawHist[0];
      else s = '0;

      mDone = 0;
      if (pClr) begin
        mAcc = 0; mOvf = 0; mBusy = 0; mInDone = 0; mRemain = 0;
      end else if (!mBusy) begin
        if (pExe) begin
          mOp1 = 32'($signed(mAcc));
          mOp2 = 32'($signed(s.sw));
          mSel = s.sel;
          mBusy = 1;
          mRemain = LAT;
        end
      end else if (mInDone) begin
        mBusy = 0;
        mInDone = 0;
      end else begin
        mRemain--;
        if (mRemain == 0) begin
          res = aluFn(mOp1, mOp2, mSel);
`ifdef CALC_SEQ_SAT_EN
          if ($signed(res) > 32'sd32767) begin
            mAcc = 16'h7FFF; mOvf = 1;
          end else if ($signed(res) < -32'sd32768) begin
            mAcc = 16'h8000; mOvf = 1;
          end else begin
            mAcc = res[15:0];
          end
`else
          mAcc = res[15:0];
`endif
          mDone = 1;
          mInDone = 1;
        end
      end

      winU.push_back(s.u);
      if (winU.size() > DB) void'(winU.pop_front());
      winD.push_back(s.d);
      if (winD.size() > DB) void'(winD.pop_front());
      newClr = 0;
      newExe = 0;
      if (winU.size() == DB && allOpposite(winU, lvlU)) begin
        lvlU = ~lvlU;
        newClr = lvlU;
      end
      if (winD.size() == DB && allOpposite(winD, lvlD)) begin
        lvlD = ~lvlD;
        newExe = lvlD;
      end
      pClr = newClr;
      pExe = newExe;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("cyc_led", {16'h0, led}, {16'h0, mAcc});
      checkOutput("cyc_busy", {31'h0, busy}, {31'h0, mBusy});
      checkOutput("cyc_done", {31'h0, done}, {31'h0, mDone});
      checkOutput("cyc_ovf", {31'h0, ovf}, {31'h0, mOvf});
      checkOutput("cyc_op1", aluOp1, mOp1);
      checkOutput("cyc_op2", aluOp2, mOp2);
      checkOutput("cyc_opsel", {29'h0, opSel}, {29'h0, mSel});
      if (done === 1'b1) doneCount++;
      if (busy === 1'b1) busySeen = 1;
    end
  end

  task automatic applyStimulus(input logic u, input logic d, input int hold, input int settle);
    btnu = u;
    btnd = d;
    repeat (hold) @(negedge clk);
    btnu = 0;
    btnd = 0;
    repeat (settle) @(negedge clk);
  endtask

  initial begin
    rst = 1; btnu = 0; btnd = 0; btnl = 0; btnc = 0; btnr = 0; sw = 16'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_led", {16'h0, led}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_ovf", {31'h0, ovf}, 32'h0);
    checkOutput("rst_op1", aluOp1, 32'h0);
    checkOutput("rst_op2", aluOp2, 32'h0);
    checkOutput("rst_opsel", {29'h0, opSel}, 32'h0);
    rst = 0;

    sw = 16'h0005;
    doneCount = 0;
    applyStimulus(1'b0, 1'b1, 8, 20);
    checkOutput("add_op2", aluOp2, 32'h00000005);
    checkOutput("add_led", {16'h0, led}, 32'h00000005);
    checkOutput("add_model_led", {16'h0, mAcc}, 32'h00000005);
    checkOutput("add_done_pulses", doneCount, 1);

    sw = 16'hFFFD;
    btnr = 1;
    applyStimulus(1'b0, 1'b1, 8, 20);
    checkOutput("sub_op1", aluOp1, 32'h00000005);
    checkOutput("sub_op2", aluOp2, 32'hFFFFFFFD);
    checkOutput("sub_opsel", {29'h0, opSel}, 32'h1);
    checkOutput("sub_led", {16'h0, led}, 32'h00000008);

    busySeen = 0;
    doneCount = 0;
    applyStimulus(1'b0, 1'b1, 2, 15);
    checkOutput("glitch_busy_seen", {31'h0, busySeen}, 32'h0);
    checkOutput("glitch_led", {16'h0, led}, 32'h00000008);
    checkOutput("glitch_done_pulses", doneCount, 0);

    btnr = 0;
    sw = 16'h0001;
    busySeen = 0;
    doneCount = 0;
    btnd = 1;
    @(negedge clk);
    btnu = 1;
    repeat (7) @(negedge clk);
    btnd = 0;
    @(negedge clk);
    btnu = 0;
    repeat (20) @(negedge clk);
    checkOutput("abort_issued", {31'h0, busySeen}, 32'h1);
    checkOutput("abort_op2", aluOp2, 32'h00000001);
    checkOutput("abort_led", {16'h0, led}, 32'h0);
    checkOutput("abort_done_pulses", doneCount, 0);
    checkOutput("abort_busy", {31'h0, busy}, 32'h0);

    sw = 16'h0003;
    applyStimulus(1'b0, 1'b1, 8, 20);
    checkOutput("pre_both_led", {16'h0, led}, 32'h00000003);
    busySeen = 0;
    doneCount = 0;
    applyStimulus(1'b1, 1'b1, 8, 20);
    checkOutput("both_led", {16'h0, led}, 32'h0);
    checkOutput("both_busy_seen", {31'h0, busySeen}, 32'h0);
    checkOutput("both_done_pulses", doneCount, 0);

    sw = 16'h7FFF;
    applyStimulus(1'b0, 1'b1, 8, 20);
    checkOutput("max_led", {16'h0, led}, 32'h00007FFF);
    sw = 16'h0001;
    applyStimulus(1'b0, 1'b1, 8, 20);
`ifdef CALC_SEQ_SAT_EN
    checkOutput("ovf_led", {16'h0, led}, 32'h00007FFF);
    checkOutput("ovf_flag", {31'h0, ovf}, 32'h1);
    checkOutput("ovf_model_led", {16'h0, mAcc}, 32'h00007FFF);
`else
    checkOutput("ovf_led", {16'h0, led}, 32'h00008000);
    checkOutput("ovf_flag", {31'h0, ovf}, 32'h0);
    checkOutput("ovf_model_led", {16'h0, mAcc}, 32'h00008000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/calc_seq.md
# calc_seq

Controller for the calculator datapath. Debounces the front-panel buttons and owns the 16-bit accumulator. On each execute press it latches the switch operand and the operation select, presents sign-extended operands to the shared 32-bit ALU, waits a configurable ALU latency, and writes the result back into the accumulator, which drives the LEDs. It sits between the board I/O and the ALU/op-encoder pair and replaces free-running button-clocked accumulator updates with a single-clock sequenced flow.

## Interface
Parameters:
- DB_CYCLES, 16 — consecutive stable samples required before a button level is accepted (≥1)
- ALU_LAT, 1 — cycles operands are held stable before `alu_result` is sampled (≥1)

Ports:
- clk  in  1  — single clock; all logic on rising edge
- rst  in  1  — reset, synchronous and active-high
- btnu  in  1  — raw button: clear accumulator
- btnd  in  1  — raw button: execute
- btnl, btnc, btnr  in  1 each  — raw operation-select buttons
- sw  in  16  — operand switches, two's complement
- alu_result  in  32  — ALU result
- alu_op1  out  32  — sign-extended accumulator operand
- alu_op2  out  32  — sign-extended switch operand
- op_sel  out  3  — {btnl,btnc,btnr} latched at issue; drives the op encoder
- led  out  16  — accumulator value
- busy  out  1  — operation in flight
- done  out  1  — one-cycle pulse on accumulator write
- ovf  out  1  — sticky overflow flag (see Configuration)

## Operation
- All raw inputs pass through 2-flop synchronizers. btnl/btnc/btnr/sw are used as synchronized levels, not debounced.
- Debounce for btnu and btnd: per-button counter. Debounced level flips only after DB_CYCLES consecutive synchronized samples differ from the current level. Counter resets on any agreeing sample.
- Press event: one-cycle registered pulse on the debounced rising edge. Release generates nothing.
- FSM states: IDLE, WAIT, DONE.
  - IDLE + execute press: latch `alu_op1={{16{acc[15]}},acc}`, `alu_op2={{16{sw[15]}},sw}`, `op_sel`. Clear cnt and go to WAIT.
  - WAIT: cnt increments each cycle. At the edge where cnt==ALU_LAT-1, write acc from `alu_result` and go to DONE.
  - DONE: `done`=1 for this one cycle, then go to IDLE.
- Operands and `op_sel` hold their last values in IDLE and are stable throughout WAIT.
- Write-back: acc <= alu_result[15:0]. Exception: with the saturation feature, see Configuration.
- `led` = acc (registered; no extra delay). `busy` = (state != IDLE).
- Clear press, in any state: acc <= 0, ovf <= 0, state <= IDLE. Any in-flight operation is aborted: no write, no `done`.
- Clear and execute press in the same cycle: clear wins and the execute is discarded.
- Execute press while busy: dropped. It is not queued.
- rst: acc, led, alu_op1, alu_op2, op_sel, busy, done, ovf all 0. State IDLE. Synchronizers, debounced levels and counters all 0.
- rst mid-operation: aborts with no write.

## Timing
- Button to press pulse: 2 sync cycles + DB_CYCLES, ±1 cycle.
- Press pulse in cycle N (IDLE): operands valid from cycle N+1.
- acc/led update at the edge ending cycle N+ALU_LAT. `done` is high in cycle N+ALU_LAT+1.
- Next execute is accepted from cycle N+ALU_LAT+2.
- Clear pulse in cycle N: acc=0 from cycle N+1.

## Configuration
- CALC_SEQ_SAT_EN defined:
  - Write-back saturates to the 16-bit signed range.
  - If alu_result[31:15] is not all-equal, acc <= 16'h7FFF when alu_result[31]=0, else 16'h8000.
  - `ovf` is set and stays set until clear or rst.
- CALC_SEQ_SAT_EN undefined:
  - Truncating write of alu_result[15:0].
  - `ovf` is tied to 0.

## Test plan
Bench settings: DB_CYCLES=4, ALU_LAT=2. Behavioural ALU model: op_sel 3'b000 add, 3'b001 subtract.
- rst, then sw=16'h0005, op_sel=000, pulse btnd for 8 cycles -> alu_op2=32'h00000005; led=16'h0005 exactly ALU_LAT cycles after operand issue; `done` pulses once.
- Then sw=16'hFFFD (−3), op_sel=001 -> alu_op1=32'h00000005, alu_op2=32'hFFFFFFFD; led=16'h0008.
- btnd glitch of 2 cycles high -> no press, busy stays 0, led unchanged.
- btnd press, then btnu press landing in WAIT -> led=16'h0000, no `done`, busy=0 next cycle. A second btnd during the same busy window is ignored.
- btnu and btnd debounced in the same cycle -> led=16'h0000, no operation issued.
- acc=16'h7FFF, sw=16'h0001, add -> with CALC_SEQ_SAT_EN: led=16'h7FFF, ovf=1. Without: led=16'h8000, ovf=0.
